// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared definitions for the instruction fetch/sequencing engine:
//   default widths, the sequencer state encoding and the opcode values
//   that the Control decoder recognises.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  localparam int PC_W     = 10;
  localparam int INSTR_W  = 16;
  localparam int OFFSET_W = 8;
  localparam int CNT_W    = 16;
  localparam int OPC_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [OPC_W-1:0] kOP_LOAD  = 4'd0;
  localparam logic [OPC_W-1:0] kOP_ADDI  = 4'd1;
  localparam logic [OPC_W-1:0] kOP_STORE = 4'd2;
  localparam logic [OPC_W-1:0] kOP_BEQZ  = 4'd3;
  localparam logic [OPC_W-1:0] kOP_HALT  = 4'd15;

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pc_next
//   Combinational next-PC computation.
//   Ports:
//     i_pc      current PC (address of the executing instruction)
//     i_offset  signed branch offset taken from the IR
//     i_take    1 = branch taken (BRANCH & ZERO), 0 = sequential
//     o_pc_next PC+1 or PC+sext(offset), modulo 2^PC_W
// -----------------------------------------------------------------------------
module fetch_sequencer_pc_next
  import fetch_sequencer_pkg::*;
#(
  parameter int P_PC_W     = PC_W,
  parameter int P_OFFSET_W = OFFSET_W
) (
  input  logic [P_PC_W-1:0]     i_pc,
  input  logic [P_OFFSET_W-1:0] i_offset,
  input  logic                  i_take,
  output logic [P_PC_W-1:0]     o_pc_next
);

  logic [P_PC_W-1:0] w_offset_sext;
  logic [P_PC_W-1:0] w_pc_seq;
  logic [P_PC_W-1:0] w_pc_branch;

  // Sign-extend the offset bit by bit; bits above the offset width copy its MSB.
  for (genvar gi = 0; gi < P_PC_W; gi++) begin : g_sext
    if (gi < P_OFFSET_W) begin : g_low
      assign w_offset_sext[gi] = i_offset[gi];
    end else begin : g_high
      assign w_offset_sext[gi] = i_offset[P_OFFSET_W-1];
    end
  end

  // Both sums drop the carry out, so targets wrap around the address space.
  assign w_pc_seq    = i_pc + {{(P_PC_W-1){1'b0}}, 1'b1};
  assign w_pc_branch = i_pc + w_offset_sext;
  assign o_pc_next   = i_take ? w_pc_branch : w_pc_seq;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Multi-cycle fetch/sequencing engine. Owns PC and IR, fetches from IMEM
//   over a req/valid handshake, presents one instruction per EXEC window and
//   advances the PC sequentially or by a relative branch.
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     i_start/_addr       start pulse and initial PC (honoured in IDLE/HALTED)
//     o_imem_req/_addr    fetch request (held until valid) and address (= PC)
//     i_imem_valid/_rdata fetched instruction strobe and data
//     o_opcode, o_instr   IR opcode field and full IR
//     o_instr_valid       IR is executing this cycle
//     i_branch, i_halt    decoder outputs, sampled in EXEC
//     i_zero              ALU zero flag, qualifies branches
//     i_stall             hold EXEC (PC, IR, counter frozen)
//     o_pc                current PC
//     o_done              program halted, held until next start
//     o_retired           saturating retired-instruction count
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int P_PC_W     = PC_W,
  parameter int P_INSTR_W  = INSTR_W,
  parameter int P_OFFSET_W = OFFSET_W,
  parameter int P_CNT_W    = CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [P_PC_W-1:0]    i_start_addr,
  output logic                 o_imem_req,
  output logic [P_PC_W-1:0]    o_imem_addr,
  input  logic                 i_imem_valid,
  input  logic [P_INSTR_W-1:0] i_imem_rdata,
  output logic [OPC_W-1:0]     o_opcode,
  output logic [P_INSTR_W-1:0] o_instr,
  output logic                 o_instr_valid,
  input  logic                 i_branch,
  input  logic                 i_halt,
  input  logic                 i_zero,
  input  logic                 i_stall,
  output logic [P_PC_W-1:0]    o_pc,
  output logic                 o_done,
  output logic [P_CNT_W-1:0]   o_retired
);

  fetch_state_t         r_state;
  logic [P_PC_W-1:0]    r_pc;
  logic [P_INSTR_W-1:0] r_ir;
  logic [P_CNT_W-1:0]   r_retired;
  logic                 r_imem_req;
  logic                 r_instr_valid;
  logic                 r_done;

  logic [P_PC_W-1:0]    w_pc_next;
  logic                 w_take;

  assign w_take = i_branch & i_zero;

  fetch_sequencer_pc_next #(
    .P_PC_W     (P_PC_W),
    .P_OFFSET_W (P_OFFSET_W)
  ) u_pc_next (
    .i_pc      (r_pc),
    .i_offset  (r_ir[P_OFFSET_W-1:0]),
    .i_take    (w_take),
    .o_pc_next (w_pc_next)
  );

  // Single-process FSM; the handshake/status outputs are registered so they
  // change together with the state and are all zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_retired     <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HALTED: begin
          if (i_start) begin
            r_pc       <= i_start_addr;
            r_retired  <= '0;
            r_done     <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          if (i_imem_valid) begin
            r_ir          <= i_imem_rdata;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= EXEC;
          end
        end
        EXEC: begin
          if (!i_stall) begin
            r_instr_valid <= 1'b0;
            // Counter sticks at all-ones instead of wrapping.
            if (r_retired != {P_CNT_W{1'b1}}) begin
              r_retired <= r_retired + {{(P_CNT_W-1){1'b0}}, 1'b1};
            end
            // HALT wins over BRANCH; the PC stays on the halting instruction.
            if (i_halt) begin
              r_done  <= 1'b1;
              r_state <= HALTED;
            end else begin
              r_pc       <= w_pc_next;
              r_imem_req <= 1'b1;
              r_state    <= FETCH;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_instr       = r_ir;
  assign o_opcode      = r_ir[P_INSTR_W-1 -: OPC_W];
  assign o_instr_valid = r_instr_valid;
  assign o_done        = r_done;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic [PC_W-1:0]    i_start_addr = '0;
  logic               o_imem_req;
  logic [PC_W-1:0]    o_imem_addr;
  logic               i_imem_valid = 1'b0;
  logic [INSTR_W-1:0] i_imem_rdata = '0;
  logic [OPC_W-1:0]   o_opcode;
  logic [INSTR_W-1:0] o_instr;
  logic               o_instr_valid;
  logic               i_branch = 1'b0;
  logic               i_halt = 1'b0;
  logic               i_zero = 1'b0;
  logic               i_stall = 1'b0;
  logic [PC_W-1:0]    o_pc;
  logic               o_done;
  logic [CNT_W-1:0]   o_retired;

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_start_addr  (i_start_addr),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_valid  (i_imem_valid),
    .i_imem_rdata  (i_imem_rdata),
    .o_opcode      (o_opcode),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .i_branch      (i_branch),
    .i_halt        (i_halt),
    .i_zero        (i_zero),
    .i_stall       (i_stall),
    .o_pc          (o_pc),
    .o_done        (o_done),
    .o_retired     (o_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [PC_W-1:0] pc;
    logic [15:0]     instr;
    logic            br;
    logic            z;
    logic            h;
    logic            exp_halt;
    logic [PC_W-1:0] exp_next;
  } vec_t;

  vec_t vecs[9];
  logic [15:0] halt_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse START at addr; ends on the negedge where FETCH is visible.
  task automatic do_start(input logic [PC_W-1:0] addr);
    i_start = 1'b1;
    i_start_addr = addr;
    @(negedge clk);
    i_start = 1'b0;
    check("start_req", 32'(o_imem_req), 32'd1);
    check("start_addr", 32'(o_imem_addr), 32'(addr));
    check("start_done_clr", 32'(o_done), 32'd0);
    check("start_ret_clr", 32'(o_retired), 32'd0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !o_imem_req; i++) @(negedge clk);
    check("req_seen", 32'(o_imem_req), 32'd1);
  endtask

  // Answer an outstanding fetch after lat cycles; optionally pulse START mid-fetch.
  task automatic serve(input logic [15:0] data, input int lat, input bit start_glitch);
    logic [PC_W-1:0] a0;
    a0 = o_imem_addr;
    for (int i = 1; i < lat; i++) begin
      if (start_glitch && i == 1) begin
        i_start = 1'b1;
        i_start_addr = 10'h003;
      end
      @(negedge clk);
      i_start = 1'b0;
      check("req_hold", 32'(o_imem_req), 32'd1);
      check("addr_hold", 32'(o_imem_addr), 32'(a0));
    end
    i_imem_valid = 1'b1;
    i_imem_rdata = data;
    @(negedge clk);
    i_imem_valid = 1'b0;
    i_imem_rdata = '0;
    check("exec_entry", 32'(o_instr_valid), 32'd1);
    check("ir_load", 32'(o_instr), 32'(data));
    check("opcode", 32'(o_opcode), 32'(data[15:12]));
  endtask

  task automatic exec(input logic br, input logic z, input logic h);
    i_branch = br;
    i_zero = z;
    i_halt = h;
    @(negedge clk);
    i_branch = 1'b0;
    i_zero = 1'b0;
    i_halt = 1'b0;
    check("exec_exit", 32'(o_instr_valid), 32'd0);
  endtask

  task automatic finish_halt();
    wait_req();
    serve(halt_word, 1, 1'b0);
    exec(1'b0, 1'b0, 1'b1);
    check("halt_done", 32'(o_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int iv_cnt;
    halt_word = {kOP_HALT, 12'h000};
    vecs[0] = '{"beqz_taken_back", 10'h020, {kOP_BEQZ, 4'h0, 8'hFC}, 1, 1, 0, 0, 10'h01C};
    vecs[1] = '{"beqz_not_taken",  10'h020, {kOP_BEQZ, 4'h0, 8'hFC}, 1, 0, 0, 0, 10'h021};
    vecs[2] = '{"wrap_seq",        10'h3FF, {kOP_ADDI, 12'h005},     0, 0, 0, 0, 10'h000};
    vecs[3] = '{"wrap_branch",     10'h001, {kOP_BEQZ, 4'h0, 8'hFE}, 1, 1, 0, 0, 10'h3FF};
    vecs[4] = '{"self_loop",       10'h050, {kOP_BEQZ, 4'h0, 8'h00}, 1, 1, 0, 0, 10'h050};
    vecs[5] = '{"max_fwd",         10'h100, {kOP_BEQZ, 4'h0, 8'h7F}, 1, 1, 0, 0, 10'h17F};
    vecs[6] = '{"max_back",        10'h100, {kOP_BEQZ, 4'h0, 8'h80}, 1, 1, 0, 0, 10'h080};
    vecs[7] = '{"halt_priority",   10'h030, {kOP_HALT, 12'h0FC},     1, 1, 1, 1, 10'h030};
    vecs[8] = '{"zero_no_branch",  10'h040, {kOP_LOAD, 12'h003},     0, 1, 0, 0, 10'h041};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", 32'(o_imem_req), 32'd0);
    check("rst_pc", 32'(o_pc), 32'd0);
    check("rst_ir", 32'(o_instr), 32'd0);
    check("rst_ret", 32'(o_retired), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_iv", 32'(o_instr_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset state checked");

    // 1: reset mid-fetch, late valid ignored, then fetch at 7
    do_start(10'h005);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(o_imem_req), 32'd0);
    check("midrst_pc", 32'(o_pc), 32'd0);
    @(negedge clk);
    i_imem_valid = 1'b1;
    i_imem_rdata = 16'hBEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_imem_valid = 1'b0;
    i_imem_rdata = '0;
    @(negedge clk);
    check("late_valid_req", 32'(o_imem_req), 32'd0);
    check("late_valid_ir", 32'(o_instr), 32'd0);
    check("late_valid_iv", 32'(o_instr_valid), 32'd0);
    do_start(10'h007);
    serve(halt_word, 1, 1'b0);
    exec(1'b0, 1'b0, 1'b1);
    check("t1_done", 32'(o_done), 32'd1);
    $display("reset mid-fetch sequence done");

    // 2: straight-line run
    do_start(10'h010);
    for (int i = 0; i < 4; i++) begin
      wait_req();
      check("line_addr", 32'(o_imem_addr), 32'h10 + 32'(i));
      serve((i < 3) ? {kOP_ADDI, 12'(i)} : halt_word, 1, 1'b0);
      exec(1'b0, 1'b0, (i == 3) ? 1'b1 : 1'b0);
    end
    check("line_done", 32'(o_done), 32'd1);
    check("line_ret", 32'(o_retired), 32'd4);
    check("line_pc", 32'(o_pc), 32'h13);
    $display("straight-line run done");

    // Table-driven next-PC vectors
    for (int v = 0; v < 9; v++) begin
      do_start(vecs[v].pc);
      serve(vecs[v].instr, 1, 1'b0);
      exec(vecs[v].br, vecs[v].z, vecs[v].h);
      if (vecs[v].exp_halt) begin
        check({vecs[v].name, "_done"}, 32'(o_done), 32'd1);
        check({vecs[v].name, "_pc"}, 32'(o_pc), 32'(vecs[v].exp_next));
        check({vecs[v].name, "_ret"}, 32'(o_retired), 32'd1);
      end else begin
        wait_req();
        check({vecs[v].name, "_addr"}, 32'(o_imem_addr), 32'(vecs[v].exp_next));
        check({vecs[v].name, "_ret"}, 32'(o_retired), 32'd1);
        finish_halt();
      end
      $display("vector %0d %s: pc=0x%0h instr=0x%0h next=0x%0h", v, vecs[v].name,
               vecs[v].pc, vecs[v].instr, o_imem_addr);
    end

    // 5: STALL for 3 cycles, stray IMEM_VALID ignored
    do_start(10'h060);
    serve({kOP_STORE, 12'h123}, 1, 1'b0);
    iv_cnt = 0;
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (o_instr_valid) iv_cnt++;
      check("stall_pc", 32'(o_pc), 32'h60);
      check("stall_ret", 32'(o_retired), 32'd0);
      if (k == 1) begin
        i_imem_valid = 1'b1;
        i_imem_rdata = 16'hDEAD;
      end
      @(negedge clk);
      i_imem_valid = 1'b0;
      i_imem_rdata = '0;
    end
    i_stall = 1'b0;
    if (o_instr_valid) iv_cnt++;
    check("stall_ir_kept", 32'(o_instr), 32'h2123);
    check("stall_pc_end", 32'(o_pc), 32'h60);
    exec(1'b0, 1'b0, 1'b0);
    check("stall_iv_cycles", 32'(iv_cnt), 32'd4);
    check("stall_ret_after", 32'(o_retired), 32'd1);
    wait_req();
    check("stall_next_addr", 32'(o_imem_addr), 32'h61);
    finish_halt();
    $display("stall sequence done");

    // 6: 5-cycle fetch latency, START during FETCH ignored, restart clears
    do_start(10'h080);
    serve({kOP_ADDI, 12'h001}, 5, 1'b1);
    check("lat_pc", 32'(o_pc), 32'h80);
    exec(1'b0, 1'b0, 1'b0);
    wait_req();
    check("lat_next_addr", 32'(o_imem_addr), 32'h81);
    serve(halt_word, 5, 1'b0);
    exec(1'b0, 1'b0, 1'b1);
    check("lat_done", 32'(o_done), 32'd1);
    check("lat_ret", 32'(o_retired), 32'd2);
    do_start(10'h090);
    check("restart_pc", 32'(o_pc), 32'h90);
    serve(halt_word, 1, 1'b0);
    exec(1'b0, 1'b0, 1'b1);
    check("restart_ret", 32'(o_retired), 32'd1);
    $display("variable latency / restart sequence done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
